sc_s2b_conv: RTL and testbench

SC_S2B_CONV -- requirements
Module: sc_s2b_conv

---
 rtl/sc_pkg.sv | 15 +
 rtl/sc_s2b_conv_if.sv | 24 ++
 rtl/sc_ones_counter.sv | 30 +++
 rtl/sc_s2b_conv.sv | 92 +++++++++
 tb/tb_sc_s2b_conv.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/sc_pkg.sv
// Shared types for the stochastic-to-binary converter.
// State encoding and window-length helper.
package sc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    function automatic int unsigned win_len(input int unsigned n);
        return 32'd1 << n;
    endfunction

endpackage

// File: rtl/sc_s2b_conv_if.sv
// Handshake/bus bundle for sc_s2b_conv.
// master = producer/consumer side, slave = converter side.
interface sc_s2b_conv_if #(
    parameter int N = 8
);
    logic         start;
    logic         clear;
    logic         din;
    logic         din_valid;
    logic         busy;
    logic         res_valid;
    logic         res_ready;
    logic [N+1:0] result;

    modport master (
        output start, clear, din, din_valid, res_ready,
        input  busy, res_valid, result
    );

    modport slave (
        input  start, clear, din, din_valid, res_ready,
        output busy, res_valid, result
    );
endinterface

// File: rtl/sc_ones_counter.sv
// Ones counter plus sample counter for one window of 2**N samples.
// last flags the enabled cycle that carries the final sample.
module sc_ones_counter #(
    parameter int N = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       sbit,
    output logic [N:0] ones,
    output logic       last
);
    logic [N-1:0] cnt;

    assign last = en & (&cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones <= '0;
            cnt  <= '0;
        end else if (clr) begin
            ones <= '0;
            cnt  <= '0;
        end else if (en) begin
            ones <= ones + (N+1)'(sbit);
            cnt  <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/sc_s2b_conv.sv
// Stochastic bitstream to binary converter over a 2**N sample window.
// Define SC_S2B_BIPOLAR_EN for two's-complement bipolar output.
module sc_s2b_conv
    import sc_pkg::*;
#(
    parameter int N = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    sc_s2b_conv_if.slave      bus
);
    localparam int unsigned   L  = win_len(N);
    localparam logic [N+1:0]  LV = (N+2)'(L);

    state_t       state;
    state_t       state_d;
    logic         clr;
    logic         en;
    logic         last;
    logic         load;
    logic [N:0]   ones;
    logic [N:0]   ones_fin;
    logic [N+1:0] res_d;
    logic [N+1:0] res_q;

    assign en = (state == ACCUM) & bus.din_valid & ~bus.clear;

    sc_ones_counter #(.N(N)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (en),
        .sbit  (bus.din),
        .ones  (ones),
        .last  (last)
    );

    // Final sample is folded in here so the result is ready one cycle later
    assign ones_fin = ones + (N+1)'(bus.din);

`ifdef SC_S2B_BIPOLAR_EN
    assign res_d = {ones_fin, 1'b0} - LV;
`else
    assign res_d = {1'b0, ones_fin};
`endif

    always_comb begin
        state_d = state;
        clr     = 1'b0;
        load    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_d = ACCUM;
                    clr     = 1'b1;
                end
            end
            ACCUM: begin
                if (last) begin
                    state_d = HOLD;
                    load    = 1'b1;
                end
            end
            HOLD: begin
                if (bus.res_ready) begin
                    state_d = bus.start ? ACCUM : IDLE;
                    clr     = bus.start;
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.clear) begin
            state_d = IDLE;
            clr     = 1'b1;
            load    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            res_q <= '0;
        end else begin
            state <= state_d;
            if (load) res_q <= res_d;
        end
    end

    assign bus.busy      = (state == ACCUM);
    assign bus.res_valid = (state == HOLD);
    assign bus.result    = res_q;
endmodule

// File: tb/tb_sc_s2b_conv.sv
// Scoreboard bench for sc_s2b_conv with N=3 (window of 8 samples).
// Define SC_S2B_BIPOLAR_EN to check the bipolar build.
module tb_sc_s2b_conv;
    localparam int N = 3;

    logic clk;
    logic rst_n;

    sc_s2b_conv_if #(.N(N)) bus ();

    sc_s2b_conv #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [N+1:0] expq[$];

    function automatic logic [N+1:0] expv(input int n1);
`ifdef SC_S2B_BIPOLAR_EN
        return (N+2)'(2 * n1 - 8);
`else
        return (N+2)'(n1);
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    // Monitor: every accepted result must match the queue head
    always @(negedge clk) begin
        if (rst_n && bus.res_valid && bus.res_ready) begin
            if (expq.size() == 0) begin
                chk("unexpected_result", 32'(bus.result), 32'hdead);
            end else begin
                chk("result", 32'(bus.result), 32'(expq.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send(input logic b);
        bus.din       = b;
        bus.din_valid = 1'b1;
        tick();
        bus.din_valid = 1'b0;
        bus.din       = 1'b0;
    endtask

    task automatic send_pat(input logic [7:0] p);
        for (int i = 0; i < 8; i++) send(p[i]);
    endtask

    task automatic accept();
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.clear     = 1'b0;
        bus.din       = 1'b0;
        bus.din_valid = 1'b0;
        bus.res_ready = 1'b0;
        rst_n         = 1'b0;
        #1;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_valid", 32'(bus.res_valid), 0);
        chk("rst_result", 32'(bus.result), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // all ones
        do_start();
        chk("busy_after_start", 32'(bus.busy), 1);
        send_pat(8'hff);
        chk("latency_valid", 32'(bus.res_valid), 1);
        chk("latency_busy", 32'(bus.busy), 0);
        expq.push_back(expv(8));
        accept();
        chk("idle_after_hs", 32'(bus.res_valid), 0);

        // alternating with gaps
        do_start();
        for (int i = 0; i < 8; i++) begin
            send(i[0] == 1'b0);
            if (i == 1 || i == 4 || i == 6) tick();
        end
        chk("gap_valid", 32'(bus.res_valid), 1);
        expq.push_back(expv(4));
        accept();

        // all zeros
        do_start();
        send_pat(8'h00);
        expq.push_back(expv(0));
        accept();

        // hold with backpressure, start ignored
        do_start();
        send_pat(8'b1011_0111);
        for (int i = 0; i < 5; i++) begin
            bus.start = (i == 2);
            tick();
            chk("hold_valid", 32'(bus.res_valid), 1);
            chk("hold_result", 32'(bus.result), 32'(expv(6)));
        end
        bus.start = 1'b0;
        expq.push_back(expv(6));
        bus.start     = 1'b1;
        bus.res_ready = 1'b1;
        tick();
        bus.start     = 1'b0;
        bus.res_ready = 1'b0;
        chk("restart_busy", 32'(bus.busy), 1);
        chk("restart_valid", 32'(bus.res_valid), 0);
        send_pat(8'hff);
        expq.push_back(expv(8));
        accept();

        // clear mid-window
        do_start();
        for (int i = 0; i < 5; i++) send(1'b1);
        bus.clear = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.clear = 1'b0;
        bus.start = 1'b0;
        chk("clear_busy", 32'(bus.busy), 0);
        chk("clear_valid", 32'(bus.res_valid), 0);
        chk("clear_result", 32'(bus.result), 32'(expv(8)));
        for (int i = 0; i < 4; i++) send(1'b1);
        chk("clear_stays_idle", 32'(bus.res_valid | bus.busy), 0);
        do_start();
        send_pat(8'hff);
        expq.push_back(expv(8));
        accept();

        // async reset in ACCUM
        do_start();
        send(1'b1);
        send(1'b1);
        rst_n = 1'b0;
        #1;
        chk("arst_accum_busy", 32'(bus.busy), 0);
        chk("arst_accum_result", 32'(bus.result), 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) send(1'b1);
        chk("no_start_after_rst", 32'(bus.busy | bus.res_valid), 0);

        // async reset in HOLD
        do_start();
        send_pat(8'hff);
        chk("pre_rst_hold", 32'(bus.res_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_hold_valid", 32'(bus.res_valid), 0);
        chk("arst_hold_result", 32'(bus.result), 0);
        tick();
        rst_n = 1'b1;
        tick();

        begin
            int cyc = 0;
            while (expq.size() != 0 && cyc < 20) begin
                tick();
                cyc++;
            end
        end
        chk("queue_drained", 32'(expq.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
